// File: rtl/abs_peak_finder.sv
`default_nettype none
// ============================================================================
// Module      : abs_peak_finder
// Description : Frame-based peak detector for the CalAbs magnitude stream.
//               Every N accepted samples it reports the largest magnitude and
//               the in-frame index of its first occurrence. Defining the
//               macro PEAK_AVG_EN adds a frame-mean output (avg_o).
// Revision    : 1.0 - initial release
// ============================================================================
module abs_peak_finder #(
    parameter int N  = 1024,
    parameter int DW = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          val_i,
    input  logic [DW-1:0] abs_i,
    output logic [DW-1:0] peak_o,
    output logic [AW-1:0] idx_o,
    output logic          val_o
`ifdef PEAK_AVG_EN
    ,
    output logic [DW-1:0] avg_o
`endif
);

    localparam logic [0:0]    FIRST  = 1'b0;
    localparam logic [0:0]    SEARCH = 1'b1;
    localparam logic [AW-1:0] LAST   = AW'(N - 1);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] max_r;
    logic [AW-1:0] maxidx_r;

    // Running-max candidates for the sample on the input this cycle.
    logic          gt;
    logic [DW-1:0] max_nxt;
    logic [AW-1:0] idx_nxt;
    logic          is_last;

`ifdef PEAK_AVG_EN
    logic [DW+AW-1:0] acc;
    logic [DW+AW-1:0] sum_nxt;
`endif

    // Strict compare so that ties keep the earliest index.
    always_comb begin
        gt      = (abs_i > max_r);
        max_nxt = gt ? abs_i : max_r;
        idx_nxt = gt ? cnt   : maxidx_r;
        is_last = (cnt == LAST);
`ifdef PEAK_AVG_EN
        sum_nxt = acc + {{AW{1'b0}}, abs_i};
`endif
    end

    // Frame FSM, running max and result commit; idle cycles change nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FIRST;
            cnt      <= '0;
            max_r    <= '0;
            maxidx_r <= '0;
            peak_o   <= '0;
            idx_o    <= '0;
            val_o    <= 1'b0;
`ifdef PEAK_AVG_EN
            acc      <= '0;
            avg_o    <= '0;
`endif
        end else begin
            val_o <= 1'b0;
            if (val_i) begin
                case (state)
                    FIRST: begin
                        // Sample 0 loads the running state outright, so a new
                        // frame never inherits the previous frame's maximum.
                        max_r    <= abs_i;
                        maxidx_r <= '0;
                        cnt      <= AW'(1);
                        state    <= SEARCH;
`ifdef PEAK_AVG_EN
                        acc      <= {{AW{1'b0}}, abs_i};
`endif
                    end
                    default: begin
                        max_r    <= max_nxt;
                        maxidx_r <= idx_nxt;
                        cnt      <= cnt + AW'(1);
`ifdef PEAK_AVG_EN
                        acc      <= sum_nxt;
`endif
                        // Last sample: commit including its own compare; the
                        // counter wraps to 0 naturally.
                        if (is_last) begin
                            peak_o <= max_nxt;
                            idx_o  <= idx_nxt;
                            val_o  <= 1'b1;
                            state  <= FIRST;
`ifdef PEAK_AVG_EN
                            avg_o  <= sum_nxt[DW+AW-1:AW];
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
